// File: rtl/inject_scheduler_if.sv
// ---------------------------------------------------------------------------
// inject_scheduler_if
//   Bundles the requester-facing handshake and the router-local injection
//   signals of the injection scheduler.
//
//   master : scheduler side (drives ready, inject, status)
//   slave  : environment side (requesters + router credit return)
//
//   req_flit      NREQ*FLIT_W  flit from each requester, i at [i*FLIT_W +: FLIT_W]
//   req_valid     NREQ         requester i presents a flit
//   req_last      NREQ         presented flit closes its packet
//   req_ready     NREQ         requester i's flit is accepted this cycle
//   inject        FLIT_W       flit to router local input
//   inject_valid  1            valid to router local input
//   credit_in     1            router freed one local buffer slot
//   credit_count  CNT_W        credits currently available
//   grant_id      GID_W        requester holding / last holding the grant
//   locked        1            multi-flit packet in progress
//   credit_err    1            sticky credit-overflow flag
// ---------------------------------------------------------------------------
interface inject_scheduler_if #(
    parameter int NREQ   = 4,
    parameter int FLIT_W = 20,
    parameter int CNT_W  = 3,
    parameter int GID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ*FLIT_W-1:0] req_flit;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic [FLIT_W-1:0]      inject;
    logic                   inject_valid;
    logic                   credit_in;
    logic [CNT_W-1:0]       credit_count;
    logic [GID_W-1:0]       grant_id;
    logic                   locked;
    logic                   credit_err;

    modport master (
        input  req_flit,
        input  req_valid,
        input  req_last,
        input  credit_in,
        output req_ready,
        output inject,
        output inject_valid,
        output credit_count,
        output grant_id,
        output locked,
        output credit_err
    );

    modport slave (
        output req_flit,
        output req_valid,
        output req_last,
        output credit_in,
        input  req_ready,
        input  inject,
        input  inject_valid,
        input  credit_count,
        input  grant_id,
        input  locked,
        input  credit_err
    );
endinterface

// File: rtl/inject_scheduler.sv
// ---------------------------------------------------------------------------
// inject_scheduler
//   Shares the router's single local injection port among NREQ requesters.
//   Round-robin arbitration with packet locking, credit-paced so that the
//   router's local input buffer can never overflow. Accepted flits appear on
//   inject/inject_valid exactly one cycle after the handshake.
//
//   Ports
//     clk   system clock
//     rst   synchronous reset, active-high
//     bus   inject_scheduler_if.master (requester handshake, injection
//           output, credit return and status)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no packet open; round-robin search picks the next requester
//   LOCK  | multi-flit packet open; only grant_id may send until its last
//
//   NREQ must be >= 2 and 2**CNT_W must exceed CREDITS.
// ---------------------------------------------------------------------------
module inject_scheduler #(
    parameter int NREQ    = 4,
    parameter int FLIT_W  = 20,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 3
) (
    input logic               clk,
    input logic               rst,
    inject_scheduler_if.master bus
);
    localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CNT_W-1:0] CRED_MAX  = CNT_W'(CREDITS);
    localparam logic [GID_W-1:0] GRANT_RST = GID_W'(NREQ - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [GID_W-1:0]   grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   credit_q, credit_d;
    logic               credit_err_q, credit_err_d;
    logic [FLIT_W-1:0]  inject_q, inject_d;
    logic               inject_valid_q, inject_valid_d;

    logic               winner_found;
    logic [GID_W-1:0]   winner_idx;
    logic [GID_W:0]     search_sum;
    logic [GID_W-1:0]   sel_idx;
    logic [NREQ-1:0]    ready;
    logic               has_credit;
    logic               send;
    logic               sel_last;
    logic [FLIT_W-1:0]  sel_flit;

    // Round-robin search: first valid requester strictly after grant_id_q,
    // wrapping. One extra bit on the sum keeps the wrap correct for any NREQ.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        search_sum   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            search_sum = {1'b0, grant_id_q} + (GID_W+1)'(k);
            if (search_sum >= (GID_W+1)'(NREQ)) begin
                search_sum = search_sum - (GID_W+1)'(NREQ);
            end
            if (!winner_found && bus.req_valid[search_sum[GID_W-1:0]]) begin
                winner_found = 1'b1;
                winner_idx   = search_sum[GID_W-1:0];
            end
        end
    end

    assign has_credit = (credit_q != '0);
    assign sel_idx    = (state_q == ST_LOCK) ? grant_id_q : winner_idx;

    always_comb begin
        ready = '0;
        if (has_credit) begin
            if (state_q == ST_LOCK) begin
                ready[grant_id_q] = bus.req_valid[grant_id_q];
            end else if (winner_found) begin
                ready[winner_idx] = 1'b1;
            end
        end
    end

    // At most one ready bit is set, so the OR-reduce is the single send.
    assign send     = |(bus.req_valid & ready);
    assign sel_last = bus.req_last[sel_idx];
    assign sel_flit = bus.req_flit[sel_idx*FLIT_W +: FLIT_W];

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (send) begin
                    grant_id_d = winner_idx;
                    if (!sel_last) begin
                        state_d = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                // grant_id stays put so the next search starts after it.
                if (send && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A send and a returned credit in the same cycle cancel out.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        if (send && !bus.credit_in) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (bus.credit_in && !send) begin
            if (credit_q == CRED_MAX) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        inject_d       = send ? sel_flit : inject_q;
        inject_valid_d = send;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            grant_id_q     <= GRANT_RST;
            credit_q       <= CRED_MAX;
            credit_err_q   <= 1'b0;
            inject_q       <= '0;
            inject_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_id_q     <= grant_id_d;
            credit_q       <= credit_d;
            credit_err_q   <= credit_err_d;
            inject_q       <= inject_d;
            inject_valid_q <= inject_valid_d;
        end
    end

    assign bus.req_ready    = ready;
    assign bus.inject       = inject_q;
    assign bus.inject_valid = inject_valid_q;
    assign bus.credit_count = credit_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.locked       = (state_q == ST_LOCK);
    assign bus.credit_err   = credit_err_q;

endmodule

// File: tb/tb_inject_scheduler.sv
module tb_inject_scheduler;
    localparam int NREQ    = 4;
    localparam int FLIT_W  = 20;
    localparam int CREDITS = 4;
    localparam int CNT_W   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inject_scheduler_if #(.NREQ(NREQ), .FLIT_W(FLIT_W), .CNT_W(CNT_W)) bus ();

    inject_scheduler #(
        .NREQ(NREQ), .FLIT_W(FLIT_W), .CREDITS(CREDITS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integers describing the scheduler's observable state.
    int              m_cred;
    int              m_grant;
    bit              m_lock;
    bit              m_err;
    logic [FLIT_W-1:0] m_inj;
    bit              m_inj_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cred  = CREDITS;
        m_grant = NREQ - 1;
        m_lock  = 0;
        m_err   = 0;
        m_inj   = '0;
        m_inj_v = 0;
    endtask

    // Who may send: nobody without credit; the packet owner while a packet is
    // open; otherwise the first valid requester after the last grant.
    function automatic logic [NREQ-1:0] model_ready(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] r = '0;
        if (m_cred > 0) begin
            if (m_lock) begin
                r[m_grant] = v[m_grant];
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    int i = (m_grant + k) % NREQ;
                    if (v[i] && r == '0) r[i] = 1'b1;
                end
            end
        end
        return r;
    endfunction

    task automatic check_state();
        chk("inject_valid", 32'(bus.inject_valid), 32'(m_inj_v));
        chk("inject",       32'(bus.inject),       32'(m_inj));
        chk("credit_count", 32'(bus.credit_count), 32'(m_cred));
        chk("grant_id",     32'(bus.grant_id),     32'(m_grant));
        chk("locked",       32'(bus.locked),       32'(m_lock));
        chk("credit_err",   32'(bus.credit_err),   32'(m_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        check_state();
    endtask

    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                         input logic [NREQ*FLIT_W-1:0] f, input logic c,
                         output bit sent, output int who);
        logic [NREQ-1:0] er;
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_flit  = f;
        bus.credit_in = c;
        #1;
        er = model_ready(v);
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        sent = 0;
        who  = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && er[i]) begin
                sent = 1;
                who  = i;
            end
        end
        if (sent) begin
            m_inj   = f[who*FLIT_W +: FLIT_W];
            m_inj_v = 1;
            if (!m_lock) m_grant = who;
            m_lock = !l[who];
        end else begin
            m_inj_v = 0;
        end
        if (c && !sent) begin
            if (m_cred == CREDITS) m_err = 1;
            else m_cred++;
        end else if (sent && !c) begin
            m_cred--;
        end
        @(posedge clk);
        #2;
        check_state();
    endtask

    function automatic logic [NREQ*FLIT_W-1:0] tagged_flits(input int seq);
        logic [NREQ*FLIT_W-1:0] f;
        for (int i = 0; i < NREQ; i++) f[i*FLIT_W +: FLIT_W] = FLIT_W'((i << 16) | seq);
        return f;
    endfunction

    initial begin
        bit s;
        int w;
        int nsend;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [NREQ*FLIT_W-1:0] f;
        logic [NREQ-1:0] rv, rl;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_flit  = '0;
        bus.credit_in = 1'b0;
        model_reset();
        @(posedge clk);
        do_reset();
        chk("rst_credit_lit", 32'(bus.credit_count), 32'd4);
        chk("rst_grant_lit",  32'(bus.grant_id),     32'd3);
        chk("rst_ivalid_lit", 32'(bus.inject_valid), 32'd0);

        // Single requester, single flit.
        f = '0;
        f[1*FLIT_W +: FLIT_W] = 20'h0ABCD;
        bus.req_valid = 4'b0010; bus.req_last = 4'b1111; bus.req_flit = f; bus.credit_in = 0;
        #1;
        chk("t1_ready_lit", 32'(bus.req_ready), 32'b0010);
        cycle(4'b0010, 4'b1111, f, 1'b0, s, w);
        chk("t1_inject_lit", 32'(bus.inject),       32'h0ABCD);
        chk("t1_ivalid_lit", 32'(bus.inject_valid), 32'd1);
        chk("t1_credit_lit", 32'(bus.credit_count), 32'd3);

        // Round-robin with credits returned every cycle after the first.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 4'b1111, tagged_flits(k), k != 0, s, w);
            chk("t2_order_lit", 32'(bus.grant_id), 32'(exp_order[k]));
            chk("t2_credit_lit", 32'(bus.credit_count), 32'd3);
        end

        // 3-flit packet from requester 2 while 0 and 3 are waiting.
        do_reset();
        cycle(4'b0100, 4'b1111, tagged_flits(0), 1'b0, s, w);  // grant -> 2
        cycle(4'b0010, 4'b1111, tagged_flits(0), 1'b1, s, w);  // grant -> 1 (credit back)
        for (int k = 1; k <= 3; k++) begin
            rl = (k == 3) ? 4'b1111 : 4'b1011;
            cycle(4'b1101, rl, tagged_flits(k), 1'b1, s, w);
            chk("t3_flit_lit",  32'(bus.inject), 32'h20000 + 32'(k));
            chk("t3_grant_lit", 32'(bus.grant_id), 32'd2);
            if (k < 3) chk("t3_locked_lit", 32'(bus.locked), 32'd1);
        end
        chk("t3_unlock_lit", 32'(bus.locked), 32'd0);
        cycle(4'b1001, 4'b1111, tagged_flits(4), 1'b1, s, w);
        chk("t3_next3_lit", 32'(bus.grant_id), 32'd3);
        cycle(4'b0001, 4'b1111, tagged_flits(5), 1'b1, s, w);
        chk("t3_next0_lit", 32'(bus.grant_id), 32'd0);

        // Credit exhaustion.
        do_reset();
        nsend = 0;
        for (int k = 0; k < 6; k++) begin
            cycle(4'b0001, 4'b1111, tagged_flits(k), 1'b0, s, w);
            nsend += int'(s);
        end
        chk("t4_sends_lit",  32'(nsend), 32'd4);
        chk("t4_credit_lit", 32'(bus.credit_count), 32'd0);
        chk("t4_ready_lit",  32'(bus.req_ready), 32'd0);
        nsend = 0;
        cycle(4'b0001, 4'b1111, tagged_flits(6), 1'b1, s, w);
        nsend += int'(s);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0001, 4'b1111, tagged_flits(7 + k), 1'b0, s, w);
            nsend += int'(s);
        end
        chk("t4_extra_lit", 32'(nsend), 32'd1);

        // Credit overflow is sticky until reset.
        do_reset();
        cycle(4'b0000, 4'b0000, '0, 1'b1, s, w);
        chk("t5_credit_lit", 32'(bus.credit_count), 32'd4);
        chk("t5_err_lit",    32'(bus.credit_err),   32'd1);
        cycle(4'b0000, 4'b0000, '0, 1'b0, s, w);
        chk("t5_sticky_lit", 32'(bus.credit_err), 32'd1);
        do_reset();
        chk("t5_clear_lit", 32'(bus.credit_err), 32'd0);

        // Reset in the middle of a locked packet.
        cycle(4'b0001, 4'b0000, tagged_flits(1), 1'b0, s, w);
        chk("t6_locked_lit", 32'(bus.locked), 32'd1);
        do_reset();
        chk("t6_locked0_lit", 32'(bus.locked),       32'd0);
        chk("t6_credit_lit",  32'(bus.credit_count), 32'd4);
        chk("t6_ivalid_lit",  32'(bus.inject_valid), 32'd0);
        chk("t6_grant_lit",   32'(bus.grant_id),     32'd3);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    rv[i] = ($urandom_range(0, 9) < 6);
                    rl[i] = ($urandom_range(0, 9) < 4);
                    f[i*FLIT_W +: FLIT_W] = FLIT_W'($urandom);
                end
                cycle(rv, rl, f, ($urandom_range(0, 9) < 4), s, w);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inject_scheduler.md
Name: inject_scheduler

Overview:
Sits between a node's traffic sources and the router's local injection port (port 5). It shares that single injection port among NREQ requesters using round-robin arbitration with packet locking. Flits are paced by a credit counter that mirrors the free slots of the router's local input buffer; the router's port-5 credit pulse replenishes the counter. The output drives the router's local input flit and valid directly.

Parameters:
NREQ, 4, number of requesters sharing the injection port
FLIT_W, 20, flit width in bits
CREDITS, 4, depth of the router local input buffer; this is the credit counter reset value
CNT_W, 3, credit counter width; must satisfy 2^CNT_W > CREDITS

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_flit  in  NREQ*FLIT_W  flit from each requester; requester i occupies bits [i*FLIT_W +: FLIT_W]
req_valid  in  NREQ  requester i presents a flit
req_last  in  NREQ  the presented flit is the last flit of its packet
req_ready  out  NREQ  requester i's flit is accepted this cycle (combinational)
inject  out  FLIT_W  flit to router local input (in5)
inject_valid  out  1  valid to router local input (vi5)
credit_in  in  1  one-cycle pulse from router (co5): one local buffer slot freed
credit_count  out  CNT_W  current credits available
grant_id  out  log2(NREQ)  requester currently holding or last holding the grant
locked  out  1  a multi-flit packet is in progress
credit_err  out  1  sticky flag: credit received while the counter was already at CREDITS

Behaviour:
- Reset values: inject=0, inject_valid=0, credit_count=CREDITS, grant_id=NREQ-1 (requester 0 has first priority), locked=0, credit_err=0, FSM in IDLE.
- FSM has two states, IDLE and LOCK.
- IDLE, winner selection: winner = first i with req_valid[i], searching (grant_id+1) mod NREQ upward with wrap-around.
- IDLE, ready: req_ready[winner]=1 only if credit_count>0. All other ready bits are 0.
- IDLE, accepted flit with req_last=1: stay in IDLE; grant_id<=winner.
- IDLE, accepted flit with req_last=0: go to LOCK; grant_id<=winner; locked<=1.
- LOCK, ready: only requester grant_id can be accepted, with req_ready[grant_id]=req_valid[grant_id]&&(credit_count>0). Other requesters are blocked, even if they are valid.
- LOCK, exit: accepting a flit with req_last=1 returns the FSM to IDLE and clears locked. grant_id is unchanged, so the next search starts after it.
- Send definition: a send occurs when req_valid[i]&&req_ready[i].
- Send timing: on a send, the next cycle has inject=req_flit[i] and inject_valid=1. Latency is exactly 1 cycle.
- No send: inject_valid=0 in the next cycle and inject holds its previous value.
- At most one send per cycle. Throughput is one flit per cycle while credits remain.
- Credit update on send only: credit_count decrements by 1.
- Credit update on credit_in only: credit_count increments by 1.
- Send and credit_in in the same cycle: credit_count is unchanged. This holds even when credit_count=0, because send requires credit_count>0 before the update, so the case cannot occur at 0.
- credit_in while credit_count==CREDITS with no simultaneous send: the counter saturates (stays at CREDITS) and credit_err<=1. credit_err stays 1 until rst.
- credit_count==0: no req_ready is asserted. The FSM state and grant_id hold. A LOCKED packet resumes from the same requester once credit returns.
- Requester in LOCK drops req_valid mid-packet: the scheduler waits indefinitely in LOCK. No timeout.
- No valid requesters in IDLE: there is no send and grant_id holds.
- rst asserted mid-packet: all state returns to reset values. Completing or discarding the truncated packet is the source's responsibility.

Test Plan:
- Single requester, credits available: req_valid[1]=1, last=1, flit=0x0ABCD. Required: req_ready[1]=1 the same cycle; next cycle inject=0x0ABCD, inject_valid=1, credit_count 4→3.
- All 4 requesters valid with single-flit packets, credit_in pulsed every cycle. Required: grants in order 0,1,2,3,0; credit_count stays at 3 after the first send.
- Requester 2 sends a 3-flit packet (last on flit 3) while requesters 0 and 3 are valid. Required: flits 1–3 from requester 2 on consecutive cycles with locked=1; the next grant is requester 3, then requester 0.
- Requester 0 streams 6 single-flit packets with no credit_in. Required: exactly 4 sends, credit_count=0, req_ready=0. One credit_in pulse then allows exactly 1 more send.
- credit_in pulse with credit_count=4 and no send. Required: credit_count stays 4 and credit_err=1 (sticky). rst clears credit_err to 0.
- rst asserted in LOCK after 1 of 3 flits. Required: next cycle locked=0, credit_count=4, inject_valid=0, grant_id=3.
